led_pattern_sequencer: RTL and testbench
========================================

Name: led_pattern_sequencer

Overview:
- Plays one of four fixed LED blink patterns on a single LED output.
- Each pattern is a short ROM sequence of (level, duration) steps. Durations are counted in prescaled ticks derived from the board clock.
- Start/stop/loop control makes it the scheduling front-end for waveform-generating LED outputs; it replaces free-running per-waveform counters with one sequenced controller.

Parameters:
- DIV, 50000000, clocks per duration tick (1 s at 50 MHz); legal range 1 to 2^26-1.
- CNT_W, 26, prescaler counter width; must satisfy 2^CNT_W > DIV-1.

Ports:
- iCLK  input  1  system clock, rising edge.
- iRST_N  input  1  asynchronous active-low reset.
- iSTART  input  1  start request, level-sampled each clock.
- iSTOP  input  1  abort request, level-sampled each clock.
- iLOOP  input  1  1 = repeat pattern, 0 = one-shot.
- iSEL  input  2  pattern select, latched on accepted start.
- oLED  output  1  registered LED drive.
- oBUSY  output  1  high while state = RUN.
- oDONE  output  1  one-clock pulse at one-shot completion.
- oSTEP  output  2  current step index within the pattern.
- oPAT  output  2  latched pattern number.

Behaviour:
- Reset (async, iRST_N=0):
  - state = IDLE.
  - oLED, oBUSY, oDONE, oSTEP, oPAT, prescaler and remaining-count all = 0.
- ROM entry format: {level, dur[3:0], last}. A dur of 0 is treated as 1. Contents:
  - P0: (1,2)(0,2 last)
  - P1: (1,1)(0,5 last)
  - P2: (1,1)(0,1)(1,1)(0,4 last)
  - P3: (1,3)(0,1)(1,1)(0,3 last)
- States:
  - IDLE → RUN on iSTART=1 and iSTOP=0.
  - RUN → IDLE on iSTOP=1, or at the end of a one-shot pass.
- Accepting a start (same edge):
  - oPAT <= iSEL, oSTEP <= 0.
  - oLED <= level(step 0), remaining <= dur(step 0).
  - prescaler <= 0, oBUSY <= 1.
  - Latency: oLED valid on the first edge after iSTART is sampled.
- Tick generation:
  - The prescaler counts 0..DIV-1 only in RUN and wraps.
  - tick = (prescaler == DIV-1) and state == RUN.
- On a tick with remaining > 1: remaining decrements.
- On a tick with remaining == 1, the step ends:
  - Step not last: oSTEP+1; load its level and duration on the same edge.
  - Step last and iLOOP=1: wrap to step 0 with no gap clock.
  - Step last and iLOOP=0: go to IDLE; oLED <= 0, oBUSY <= 0, oDONE <= 1 for exactly one clock.
- Step timing: each step lasts exactly dur × DIV clocks.
- iLOOP is sampled only at the end of a pass. Clearing it mid-pass finishes the current pass, then stops.
- iSEL changes while in RUN are ignored until the next start.
- iSTART while in RUN is ignored; it does not restart the pattern.
- iSTOP in any state: IDLE on the next edge.
  - oLED, oBUSY, oSTEP <= 0.
  - oDONE stays 0 (abort is not completion).
  - oPAT holds its value.
- iSTART and iSTOP asserted in the same clock: stop wins.
- iSTART held high after a one-shot completes: restarts on the clock after oDONE (IDLE for exactly one cycle).
- Reset asserted mid-pattern clears everything immediately. There is no resume after reset.

Decomposition:
- Shared package/include holds:
  - state encodings (IDLE=0, RUN=1);
  - step field widths (LVL, DUR_W=4, STEP_W=2);
  - the 4×4 pattern ROM constants.
- One sub-module, led_tick_prescaler (params DIV, CNT_W):
  - ports iCLK, iRST_N, iEN, iCLR, oTICK;
  - oTICK is combinational on (count == DIV-1) && iEN.
- The sequencer FSM, ROM lookup and step counter stay in the top module.

Test Plan (DIV=4 override):
- Reset mid-run: assert iRST_N=0 during P2 step 1 → oLED=0, oBUSY=0, oSTEP=0 immediately; stays idle after release until iSTART.
- P0 one-shot: iSEL=0, iLOOP=0, 1-clock iSTART → oLED high 8 clocks, low 8 clocks; oDONE pulses once at clock 16 after start; oBUSY falls on the same edge.
- P2 loop: iSEL=2, iLOOP=1 → LED pattern H4 L4 H4 L16 repeats with no gap; oSTEP cycles 0,1,2,3,0. Drop iLOOP during step 1 → exactly one oDONE at the end of that pass.
- Abort: start P3, assert iSTOP in step 2 → next edge oLED=0, oBUSY=0, oDONE never asserts. Assert iSTART+iSTOP together → remains IDLE.
- Latching: start P1, change iSEL to 3 and pulse iSTART mid-run → pattern stays P1 (H4 L20), oPAT=1, no restart.
- Held start: iSTART held high with P1 one-shot → oDONE pulse, one IDLE clock, then restart with oLED=1.

Source files
------------

// File: rtl/led_pattern_sequencer_pkg.sv
// led_pattern_sequencer_pkg: state encoding, step field widths and the fixed pattern ROM
package led_pattern_sequencer_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;
  localparam int LVL = 1;
  localparam int DUR_W = 4;
  localparam int STEP_W = 2;
  localparam int PAT_W = 2;
  localparam int ENT_W = LVL + DUR_W + 1;
  typedef logic [ENT_W-1:0] entry_t;
  // Entry layout {level, dur[3:0], last}; unused slots after a last step read as zero
  function automatic entry_t rom_entry(input logic [PAT_W-1:0] pat, input logic [STEP_W-1:0] step);
    case ({pat, step})
      4'h0: rom_entry = 6'b1_0010_0;
      4'h1: rom_entry = 6'b0_0010_1;
      4'h4: rom_entry = 6'b1_0001_0;
      4'h5: rom_entry = 6'b0_0101_1;
      4'h8: rom_entry = 6'b1_0001_0;
      4'h9: rom_entry = 6'b0_0001_0;
      4'hA: rom_entry = 6'b1_0001_0;
      4'hB: rom_entry = 6'b0_0100_1;
      4'hC: rom_entry = 6'b1_0011_0;
      4'hD: rom_entry = 6'b0_0001_0;
      4'hE: rom_entry = 6'b1_0001_0;
      4'hF: rom_entry = 6'b0_0011_1;
      default: rom_entry = '0;
    endcase
  endfunction
  function automatic logic ent_level(input entry_t e);
    ent_level = e[ENT_W-1];
  endfunction
  function automatic logic ent_last(input entry_t e);
    ent_last = e[0];
  endfunction
  // A zero duration would stall the step forever, so it plays as one tick
  function automatic logic [DUR_W-1:0] ent_dur(input entry_t e);
    ent_dur = (e[DUR_W:1] == '0) ? DUR_W'(1) : e[DUR_W:1];
  endfunction
endpackage

// File: rtl/led_pattern_sequencer_tick.sv
// led_tick_prescaler: divides the clock into one-cycle duration ticks while enabled
module led_tick_prescaler #(
  parameter int DIV = 50000000,
  parameter int CNT_W = 26
) (
  input  logic iCLK,
  input  logic iRST_N,
  input  logic iEN,
  input  logic iCLR,
  output logic oTICK
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign oTICK = iEN && (cnt_q == LAST);
  always_comb cnt_d = iCLR ? '0 : !iEN ? cnt_q : oTICK ? '0 : cnt_q + 1'b1;
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: plays one of four ROM blink patterns on a single LED
// with start/stop/loop control and step durations in prescaled ticks.
module led_pattern_sequencer
  import led_pattern_sequencer_pkg::*;
#(
  parameter int DIV = 50000000,
  parameter int CNT_W = 26
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iSTART,
  input  logic             iSTOP,
  input  logic             iLOOP,
  input  logic [PAT_W-1:0] iSEL,
  output logic             oLED,
  output logic             oBUSY,
  output logic             oDONE,
  output logic [STEP_W-1:0] oSTEP,
  output logic [PAT_W-1:0] oPAT
);
  state_e state_q, state_d;
  logic led_q, led_d, done_q, done_d, tick;
  logic [STEP_W-1:0] step_q, step_d, nxt_step;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  entry_t cur_ent, nxt_ent, start_ent;
  led_tick_prescaler #(.DIV(DIV), .CNT_W(CNT_W)) u_tick (
    .iCLK  (iCLK),
    .iRST_N(iRST_N),
    .iEN   (state_q == RUN),
    .iCLR  (state_q == IDLE || iSTOP),
    .oTICK (tick)
  );
  assign cur_ent = rom_entry(pat_q, step_q);
  assign nxt_step = ent_last(cur_ent) ? '0 : step_q + 1'b1;
  assign nxt_ent = rom_entry(pat_q, nxt_step);
  assign start_ent = rom_entry(iSEL, '0);
  // Stop outranks start; a looping pass wraps to step 0 on the same edge
  always_comb begin
    state_d = state_q;
    led_d = led_q;
    done_d = 1'b0;
    step_d = step_q;
    pat_d = pat_q;
    rem_d = rem_q;
    if (iSTOP) begin
      state_d = IDLE;
      led_d = 1'b0;
      step_d = '0;
      rem_d = '0;
    end else if (state_q == IDLE) begin
      if (iSTART) begin
        state_d = RUN;
        pat_d = iSEL;
        step_d = '0;
        led_d = ent_level(start_ent);
        rem_d = ent_dur(start_ent);
      end
    end else if (tick) begin
      if (rem_q > DUR_W'(1)) begin
        rem_d = rem_q - 1'b1;
      end else if (ent_last(cur_ent) && !iLOOP) begin
        state_d = IDLE;
        led_d = 1'b0;
        done_d = 1'b1;
        step_d = '0;
        rem_d = '0;
      end else begin
        step_d = nxt_step;
        led_d = ent_level(nxt_ent);
        rem_d = ent_dur(nxt_ent);
      end
    end
  end
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      led_q <= 1'b0;
      done_q <= 1'b0;
      step_q <= '0;
      pat_q <= '0;
      rem_q <= '0;
    end else begin
      state_q <= state_d;
      led_q <= led_d;
      done_q <= done_d;
      step_q <= step_d;
      pat_q <= pat_d;
      rem_q <= rem_d;
    end
  end
  assign oLED = led_q;
  assign oBUSY = (state_q == RUN);
  assign oDONE = done_q;
  assign oSTEP = step_q;
  assign oPAT = pat_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: scoreboard bench, DIV=4; expected {led,busy,done,step,pat}
// per clock are queued by the stimulus and compared one clock later by a monitor.
module tb_led_pattern_sequencer;
  logic clk = 1'b0;
  logic rst_n, start, stop, loop;
  logic [1:0] sel, step, pat;
  logic led, busy, done;
  logic [6:0] outs;
  logic [6:0] exp_q[$];
  string tag;
  int vectors = 0;
  int errs = 0;
  led_pattern_sequencer #(.DIV(4), .CNT_W(3)) dut (
    .iCLK  (clk),
    .iRST_N(rst_n),
    .iSTART(start),
    .iSTOP (stop),
    .iLOOP (loop),
    .iSEL  (sel),
    .oLED  (led),
    .oBUSY (busy),
    .oDONE (done),
    .oSTEP (step),
    .oPAT  (pat)
  );
  always #5 clk = ~clk;
  assign outs = {led, busy, done, step, pat};
  task automatic chk(input string t, input logic [6:0] got, input logic [6:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s @%0t: got %b expected %b (led,busy,done,step,pat)", t, $time, got, exp);
    end
  endtask
  function automatic logic [6:0] ev(input logic l, input logic b, input logic d, input logic [1:0] s, input logic [1:0] p);
    return {l, b, d, s, p};
  endfunction
  task automatic tk(input logic [6:0] e);
    exp_q.push_back(e);
    @(negedge clk);
  endtask
  task automatic hold(input int n, input logic [6:0] e);
    repeat (n) tk(e);
  endtask
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) chk(tag, outs, exp_q.pop_front());
  end
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop = 1'b0; sel = 2'd0;
    tag = "reset";
    repeat (2) @(negedge clk);
    chk(tag, outs, 7'b0);
    rst_n = 1'b1;
    hold(2, ev(0, 0, 0, 0, 0));
    tag = "p0_oneshot";
    start = 1'b1; tk(ev(1, 1, 0, 0, 0)); start = 1'b0;
    hold(7, ev(1, 1, 0, 0, 0));
    hold(8, ev(0, 1, 0, 1, 0));
    tk(ev(0, 0, 1, 0, 0));
    hold(2, ev(0, 0, 0, 0, 0));
    tag = "p2_loop";
    sel = 2'd2; loop = 1'b1;
    start = 1'b1; tk(ev(1, 1, 0, 0, 2)); start = 1'b0;
    hold(3, ev(1, 1, 0, 0, 2));
    hold(4, ev(0, 1, 0, 1, 2));
    hold(4, ev(1, 1, 0, 2, 2));
    hold(16, ev(0, 1, 0, 3, 2));
    hold(4, ev(1, 1, 0, 0, 2));
    tk(ev(0, 1, 0, 1, 2)); loop = 1'b0;
    hold(3, ev(0, 1, 0, 1, 2));
    hold(4, ev(1, 1, 0, 2, 2));
    hold(16, ev(0, 1, 0, 3, 2));
    tk(ev(0, 0, 1, 0, 2));
    hold(2, ev(0, 0, 0, 0, 2));
    tag = "abort";
    sel = 2'd3;
    start = 1'b1; tk(ev(1, 1, 0, 0, 3)); start = 1'b0;
    hold(11, ev(1, 1, 0, 0, 3));
    hold(4, ev(0, 1, 0, 1, 3));
    tk(ev(1, 1, 0, 2, 3));
    stop = 1'b1; tk(ev(0, 0, 0, 0, 3)); stop = 1'b0;
    hold(3, ev(0, 0, 0, 0, 3));
    tag = "start_stop";
    sel = 2'd1; start = 1'b1; stop = 1'b1;
    hold(3, ev(0, 0, 0, 0, 3));
    start = 1'b0; stop = 1'b0;
    tk(ev(0, 0, 0, 0, 3));
    tag = "latch";
    sel = 2'd1;
    start = 1'b1; tk(ev(1, 1, 0, 0, 1)); start = 1'b0;
    hold(3, ev(1, 1, 0, 0, 1));
    hold(5, ev(0, 1, 0, 1, 1));
    sel = 2'd3; start = 1'b1; tk(ev(0, 1, 0, 1, 1)); start = 1'b0;
    hold(14, ev(0, 1, 0, 1, 1));
    tk(ev(0, 0, 1, 0, 1));
    hold(2, ev(0, 0, 0, 0, 1));
    tag = "held_start";
    sel = 2'd1; start = 1'b1;
    hold(4, ev(1, 1, 0, 0, 1));
    hold(20, ev(0, 1, 0, 1, 1));
    tk(ev(0, 0, 1, 0, 1));
    tk(ev(1, 1, 0, 0, 1)); start = 1'b0;
    hold(3, ev(1, 1, 0, 0, 1));
    tk(ev(0, 1, 0, 1, 1));
    stop = 1'b1; tk(ev(0, 0, 0, 0, 1)); stop = 1'b0;
    tag = "rst_mid";
    sel = 2'd2; loop = 1'b1;
    start = 1'b1; tk(ev(1, 1, 0, 0, 2)); start = 1'b0;
    hold(3, ev(1, 1, 0, 0, 2));
    hold(2, ev(0, 1, 0, 1, 2));
    rst_n = 1'b0;
    #1;
    chk(tag, outs, 7'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold(3, ev(0, 0, 0, 0, 0));
    loop = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
